mem_arbiter: RTL and testbench

Shares one `memory_io_req`/`memory_io_rsp` memory port among `NUM_PORTS` requesters, such as the instruction and data caches. Each port has a one-entry request buffer, and the arbiter keeps one memory transaction outstanding at a time. Grants are round-robin, and the grant is held for back-to-back cache fill and write-back beats, up to `MAX_BURST` transactions. It sits between the per-core caches and the memory model or bus.

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin share of one memory port among NUM_PORTS requesters, one transaction outstanding.
// mem_req is registered (grant at T, issue at T+1); responses route back combinationally; ready drops while a port holds a request.
package mem_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  user_tag;
   } memory_io_req;

   typedef struct packed {
      logic        valid;
      logic        ready;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  user_tag;
      logic        dummy;
   } memory_io_rsp;

   localparam memory_io_req memory_io_no_req = '0;
endpackage

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int MAX_BURST = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  memory_io_req port_req [NUM_PORTS],
   output memory_io_rsp port_rsp [NUM_PORTS],
   output memory_io_req mem_req,
   input  memory_io_rsp mem_rsp
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t               state_q, state_d;
   memory_io_req         mem_req_q, mem_req_d;
   memory_io_req         pbuf_q [NUM_PORTS];
   memory_io_req         pbuf_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] pbuf_valid_q, pbuf_valid_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]        owner_q, owner_d;
   logic [BW-1:0]        burst_cnt_q, burst_cnt_d;

   logic                 rsp_hit;
   logic [NUM_PORTS-1:0] cand;
   logic                 grant_vld;
   logic [PW-1:0]        grant;
   logic [PW-1:0]        scan_idx;
   logic                 unused_ok;

   assign unused_ok = &{1'b0, mem_rsp.ready, mem_rsp.dummy};
   assign mem_req   = mem_req_q;

   always_comb begin
      rsp_hit   = (state_q == WAIT) && mem_rsp.valid;
      cand      = '0;
      scan_idx  = '0;
      grant_vld = 1'b0;
      grant     = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         cand[p] = port_req[p].valid || pbuf_valid_q[p];
      end
      if (rsp_hit) begin
         cand[owner_q] = port_req[owner_q].valid;
      end
      if (rsp_hit && port_req[owner_q].valid && (int'(burst_cnt_q) < MAX_BURST)) begin
         grant_vld = 1'b1;
         grant     = owner_q;
      end
      // rr_ptr only advances on grants out of IDLE; the owner is scanned last so waiters beat its follow-on request
      for (int i = 0; i < NUM_PORTS; i++) begin
         scan_idx = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
         if (!grant_vld && cand[scan_idx] && !(rsp_hit && (scan_idx == owner_q))) begin
            grant_vld = 1'b1;
            grant     = scan_idx;
         end
      end
      if (!grant_vld && rsp_hit && cand[owner_q]) begin
         grant_vld = 1'b1;
         grant     = owner_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = memory_io_no_req;
      pbuf_d       = pbuf_q;
      pbuf_valid_d = pbuf_valid_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      burst_cnt_d  = burst_cnt_q;

      if (rsp_hit) begin
         pbuf_valid_d[owner_q] = 1'b0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (port_req[p].valid && !pbuf_valid_d[p]) begin
            pbuf_valid_d[p] = 1'b1;
            pbuf_d[p]       = port_req[p];
         end
      end

      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               mem_req_d       = pbuf_d[grant];
               mem_req_d.valid = 1'b1;
               owner_d         = grant;
               burst_cnt_d     = BW'(1);
               rr_ptr_d        = PW'((int'(grant) + 1) % NUM_PORTS);
               state_d         = WAIT;
            end
         end
         WAIT: begin
            if (rsp_hit) begin
               if (grant_vld) begin
                  mem_req_d       = pbuf_d[grant];
                  mem_req_d.valid = 1'b1;
                  owner_d         = grant;
                  if ((grant == owner_q) && (int'(burst_cnt_q) < MAX_BURST)) begin
                     burst_cnt_d = burst_cnt_q + BW'(1);
                  end else begin
                     burst_cnt_d = BW'(1);
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_rsp[p]       = '0;
         port_rsp[p].ready = !pbuf_valid_q[p];
         if (rsp_hit && (owner_q == PW'(p))) begin
            port_rsp[p].valid    = 1'b1;
            port_rsp[p].addr     = mem_rsp.addr;
            port_rsp[p].data     = mem_rsp.data;
            port_rsp[p].user_tag = mem_rsp.user_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_req_q    <= memory_io_no_req;
         pbuf_valid_q <= '0;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         pbuf_valid_q <= pbuf_valid_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   // payload only; occupancy is tracked by pbuf_valid_q
   always_ff @(posedge clk) begin
      pbuf_q <= pbuf_d;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected requests queue per port, expected grant order queues globally.
// A reactive memory model answers each mem_req after mem_lat cycles and checks response routing.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int NP = 2;
   localparam int MB = 8;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  tag;
   } breq_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   memory_io_req port_req [NP];
   memory_io_rsp port_rsp [NP];
   memory_io_req mem_req;
   memory_io_rsp mem_rsp;

   breq_t exp_q [NP][$];
   int    grant_q [$];
   bit    b2b_q [$];

   int n_chk = 0, n_fail = 0, cyc = 0, viol_cnt = 0, mem_lat = 1;
   int pport = 0, rsp_port = 0, cnt = 0, last_rsp_cyc = -10;
   bit pend = 1'b0, abandon = 1'b0, rsp_now = 1'b0;
   logic [31:0] paddr = '0;
   logic [3:0]  ptag = '0;

   mem_arbiter #(.NUM_PORTS(NP), .MAX_BURST(MB)) dut (
      .clk      (clk),
      .reset    (reset),
      .port_req (port_req),
      .port_rsp (port_rsp),
      .mem_req  (mem_req),
      .mem_rsp  (mem_rsp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rdata(input logic [31:0] a);
      return 32'hDEADBEEF ^ (a - 32'h100);
   endfunction

   function automatic int outstanding();
      int n;
      n = grant_q.size() + int'(pend);
      for (int p = 0; p < NP; p++) n += exp_q[p].size();
      return n;
   endfunction

   // memory model: one transaction at a time, response mem_lat cycles after the request is seen
   initial begin
      int    gp;
      bit    b2b;
      breq_t e;
      mem_rsp = '0;
      forever begin
         @(negedge clk);
         mem_rsp = '0;
         rsp_now = 1'b0;
         if (pend) begin
            if (cnt > 1) begin
               cnt--;
            end else begin
               pend             = 1'b0;
               mem_rsp.valid    = 1'b1;
               mem_rsp.ready    = 1'b1;
               mem_rsp.addr     = paddr;
               mem_rsp.data     = rdata(paddr);
               mem_rsp.user_tag = ptag;
               rsp_now          = !abandon;
               rsp_port         = pport;
               last_rsp_cyc     = cyc;
               if (!abandon) begin
                  #1;
                  chk("rsp_addr", port_rsp[pport].addr, paddr);
                  chk("rsp_data", port_rsp[pport].data, rdata(paddr));
                  chk("rsp_tag", port_rsp[pport].user_tag, ptag);
               end
               abandon = 1'b0;
            end
         end
         if (mem_req.valid) begin
            chk("mreq_expected", grant_q.size() > 0, 1);
            chk("mreq_overlap", pend, 0);
            if (grant_q.size() > 0) begin
               gp  = grant_q.pop_front();
               b2b = b2b_q.pop_front();
               chk("mreq_port_has_req", exp_q[gp].size() > 0, 1);
               if (exp_q[gp].size() > 0) begin
                  e = exp_q[gp].pop_front();
                  chk("mreq_addr", mem_req.addr, e.addr);
                  chk("mreq_tag", mem_req.user_tag, e.tag);
               end
               if (b2b) chk("b2b_issue_cycle", cyc, last_rsp_cyc + 1);
               pend  = 1'b1;
               cnt   = mem_lat;
               pport = gp;
               paddr = mem_req.addr;
               ptag  = mem_req.user_tag;
            end
         end
      end
   end

   // every cycle: only the expected port may see a response; also watch for requests into a full buffer
   always @(negedge clk) begin
      #3;
      for (int p = 0; p < NP; p++) begin
         chk("rsp_vld", port_rsp[p].valid, rsp_now && (p == rsp_port));
         if (port_req[p].valid && !port_rsp[p].ready && !port_rsp[p].valid) begin
            viol_cnt++;
            $display("protocol: port %0d requested while not ready (cycle %0d)", p, cyc);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
      for (int p = 0; p < NP; p++) port_req[p] = '0;
   endtask

   task automatic issue(input int p, input logic [31:0] a, input logic [3:0] t, input bit accept);
      breq_t e;
      port_req[p].valid    = 1'b1;
      port_req[p].write    = 1'b0;
      port_req[p].addr     = a;
      port_req[p].data     = '0;
      port_req[p].user_tag = t;
      e.addr = a;
      e.tag  = t;
      if (accept) exp_q[p].push_back(e);
   endtask

   task automatic expect_grant(input int p, input bit b2b);
      grant_q.push_back(p);
      b2b_q.push_back(b2b);
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget && outstanding() != 0; c++) step();
      step();
      chk("drained", outstanding(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic run_burst(input int n, input bit with_p0);
      int beats;
      bit sent0;
      for (int k = 0; k < n; k++) begin
         if (with_p0 && k == MB) expect_grant(0, 1'b1);
         expect_grant(1, k > 0);
      end
      if (with_p0 && n <= MB) expect_grant(0, 1'b1);
      step();
      issue(1, 32'h200, 4'h5, 1'b1);
      beats = 1;
      sent0 = !with_p0;
      for (int c = 0; c < 400 && (beats < n || !sent0); c++) begin
         step();
         if (!sent0 && beats == 2) begin
            issue(0, 32'h500, 4'h3, 1'b1);
            sent0 = 1'b1;
         end
         if (port_rsp[1].valid && beats < n) begin
            issue(1, 32'h200 + 32'(4 * beats), 4'h5, 1'b1);
            beats++;
         end
      end
      chk("burst_beats", beats, n);
      wait_done(100);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int v0;
      bit got;
      for (int p = 0; p < NP; p++) port_req[p] = '0;
      do_reset();
      step();
      chk("rst_mreq_vld", mem_req.valid, 0);
      chk("rst_mreq_addr", mem_req.addr, 0);
      for (int p = 0; p < NP; p++) begin
         chk("rst_ready", port_rsp[p].ready, 1);
         chk("rst_rsp_vld", port_rsp[p].valid, 0);
      end

      // single read: issue at T+1, response at T+4 with lat 3, ready returns the cycle after
      mem_lat = 3;
      step();
      t0 = cyc;
      issue(0, 32'h100, 4'h1, 1'b1);
      expect_grant(0, 1'b0);
      step();
      chk("lat_mreq_vld", mem_req.valid, 1);
      chk("lat_mreq_addr", mem_req.addr, 32'h100);
      chk("busy_ready", port_rsp[0].ready, 0);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         step();
         if (port_rsp[0].valid) begin
            got = 1'b1;
            chk("rsp_cycle", cyc, t0 + 4);
            chk("rsp_data0", port_rsp[0].data, 32'hDEADBEEF);
            chk("rsp_cycle_ready", port_rsp[0].ready, 0);
         end
      end
      chk("rsp_seen", got, 1);
      step();
      chk("ready_back", port_rsp[0].ready, 1);
      wait_done(20);

      // contention from reset, tags 3 and 5; second pair starts from port1
      do_reset();
      mem_lat = 2;
      step();
      issue(0, 32'h300, 4'h3, 1'b1);
      issue(1, 32'h400, 4'h5, 1'b1);
      expect_grant(0, 1'b0);
      expect_grant(1, 1'b1);
      wait_done(40);
      step();
      issue(0, 32'h304, 4'h3, 1'b1);
      issue(1, 32'h404, 4'h5, 1'b1);
      expect_grant(1, 1'b0);
      expect_grant(0, 1'b1);
      wait_done(40);

      // burst hold: full 8-beat line, a stream past the limit, and a solo stream past the limit
      mem_lat = 1;
      run_burst(8, 1'b1);
      run_burst(12, 1'b1);
      run_burst(10, 1'b0);

      // reset while waiting on memory: the late response must be dropped
      mem_lat = 4;
      step();
      issue(0, 32'h600, 4'h3, 1'b1);
      expect_grant(0, 1'b0);
      step();
      chk("pre_rst_mreq_vld", mem_req.valid, 1);
      reset   = 1'b1;
      abandon = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_mreq_vld", mem_req.valid, 0);
      for (int p = 0; p < NP; p++) chk("mid_rst_ready", port_rsp[p].ready, 1);
      wait_done(20);
      step();
      issue(1, 32'h700, 4'h5, 1'b1);
      expect_grant(1, 1'b0);
      wait_done(20);

      // protocol violation: second request into a full buffer is dropped
      chk("no_viol_yet", viol_cnt, 0);
      v0 = viol_cnt;
      mem_lat = 3;
      step();
      issue(0, 32'h800, 4'h3, 1'b1);
      expect_grant(0, 1'b0);
      step();
      issue(0, 32'h804, 4'h3, 1'b0);
      wait_done(30);
      chk("viol_flagged", viol_cnt - v0, 1);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
